fact_cu: RTL and testbench

- Control unit for the factorial engine; sits directly upstream of the factorial datapath.
- Sequences the datapath's counter and register via load_cnt, load_reg, en, sel1 and sel2.
- Consumes the datapath status flags data_error and data_gt.
- Provides a go/done/error handshake to the user side, a multiply-iteration watchdog, and a state debug output.

---
 rtl/fact_cu.sv | 100 ++++++++++
 tb/tb_fact_cu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fact_cu.sv
// Factorial engine control unit.
// Sequences the datapath down-counter and product register, offers a
// go/done/error handshake, and bounds the number of multiply iterations
// with a watchdog so a stuck data_gt flag cannot hang the engine.
module fact_cu #(
   parameter int MAX_ITER = 12,
   parameter int ITER_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic       data_error,
   input  logic       data_gt,
   output logic       load_cnt,
   output logic       load_reg,
   output logic       en,
   output logic       sel1,
   output logic       sel2,
   output logic       done,
   output logic       error,
   output logic [2:0] cs
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_CHECK = 3'd2,
      S_MULT  = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam logic [ITER_W-1:0] LP_MAX_ITER = ITER_W'(MAX_ITER);

   state_t            r_state;
   state_t            w_next;
   logic [ITER_W-1:0] r_iter;

   // State register; reset wins in every state, including mid-computation.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Iteration counter: cleared on INIT, counts MULT cycles, saturates at the limit.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_iter <= '0;
      else if (r_state == S_INIT)
         r_iter <= '0;
      else if ((r_state == S_MULT) && (r_iter != LP_MAX_ITER))
         r_iter <= r_iter + 1'b1;
   end

   // Next-state logic and Moore output decode from the state register only.
   always_comb begin
      w_next   = r_state;
      load_cnt = 1'b0;
      load_reg = 1'b0;
      en       = 1'b0;
      sel1     = 1'b0;
      sel2     = 1'b0;
      done     = 1'b0;
      error    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (go) w_next = data_error ? S_ERR : S_INIT;
         end
         S_INIT: begin
            load_cnt = 1'b1;
            load_reg = 1'b1;
            sel1     = 1'b1;
            w_next   = S_CHECK;
         end
         S_CHECK: begin
            if (!data_gt)                  w_next = S_DONE;
            else if (r_iter == LP_MAX_ITER) w_next = S_ERR;
            else                           w_next = S_MULT;
         end
         S_MULT: begin
            load_reg = 1'b1;
            en       = 1'b1;
            w_next   = S_CHECK;
         end
         S_DONE: begin
            sel2 = 1'b1;
            done = 1'b1;
            if (!go) w_next = S_IDLE;
         end
         S_ERR: begin
            error = 1'b1;
            if (!go) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign cs = r_state;

endmodule

// File: tb/tb_fact_cu.sv
// Scoreboard bench for fact_cu with a behavioural factorial datapath attached.
module tb_fact_cu;

   logic       clk;
   logic       rst_n;
   logic       go;
   logic       data_error;
   logic       data_gt;
   logic       load_cnt;
   logic       load_reg;
   logic       en;
   logic       sel1;
   logic       sel2;
   logic       done;
   logic       error;
   logic [2:0] cs;

   fact_cu #(.MAX_ITER(12), .ITER_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .data_error(data_error), .data_gt(data_gt),
      .load_cnt(load_cnt), .load_reg(load_reg), .en(en), .sel1(sel1), .sel2(sel2),
      .done(done), .error(error), .cs(cs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural datapath
   int unsigned n_in;
   bit          force_gt;
   int unsigned dp_cnt;
   int unsigned dp_reg;
   wire [31:0]  product = sel2 ? dp_reg : 32'd0;

   assign data_error = (n_in > 12);
   assign data_gt    = force_gt || (dp_cnt > 1);

   always @(posedge clk) begin
      if (load_cnt)  dp_cnt <= n_in;
      else if (en)   dp_cnt <= dp_cnt - 1;
      if (load_reg)  dp_reg <= sel1 ? 32'd1 : dp_reg * dp_cnt;
   end

   // Scoreboard
   typedef struct {
      bit          err;
      int unsigned prod;
      int          lat;
      int          ens;
      int          lcnt;
   } exp_t;
   exp_t exp_q[$];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // Monitor: measures each transaction and compares it with the queue head.
   bit       mon_en = 0;
   bit       active = 0;
   logic [2:0] prev_cs = 3'd0;
   bit       prev_term = 0;
   int       edge_n, en_n, lc_n;

   always @(negedge clk) begin
      bit   term;
      exp_t e;
      term = done || error;
      if (mon_en) begin
         if (!active && prev_cs == 3'd0 && cs != 3'd0) begin
            active = 1; edge_n = 1; en_n = 0; lc_n = 0;
         end else if (active) begin
            edge_n++;
         end
         if (active) begin
            if (en) en_n++;
            if (load_cnt) lc_n++;
         end
         if (cs == 3'd0) active = 0;
         if (active && term && !prev_term) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("err_flag", error, e.err);
               chk("done_flag", done, !e.err);
               chk("product", product, e.prod);
               chk("latency", edge_n, e.lat);
               chk("en_cycles", en_n, e.ens);
               chk("load_cnt_cycles", lc_n, e.lcnt);
            end
            active = 0;
         end
      end
      prev_cs   = cs;
      prev_term = term;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_term(input int budget);
      int k;
      k = 0;
      while (!(done || error) && k < budget) begin
         tick();
         k++;
      end
      if (!(done || error)) chk("term_timeout", 0, 1);
   endtask

   task automatic push(input bit err, input int unsigned prod, input int lat,
                       input int ens, input int lcnt);
      exp_t e;
      e.err = err; e.prod = prod; e.lat = lat; e.ens = ens; e.lcnt = lcnt;
      exp_q.push_back(e);
   endtask

   // One full transaction; drop_early releases go right after it is sampled.
   task automatic run(input int unsigned n, input bit drop_early, input bit err,
                      input int unsigned prod, input int lat, input int ens, input int lcnt);
      n_in = n;
      push(err, prod, lat, ens, lcnt);
      go = 1'b1;
      tick();
      if (drop_early) go = 1'b0;
      wait_term(60);
      go = 1'b0;
      tick();
      chk("back_to_idle", cs, 0);
   endtask

   initial begin
      int mults;
      rst_n = 1'b0; go = 1'b1; n_in = 5; force_gt = 0;
      dp_cnt = 0; dp_reg = 0;

      // Reset with go high, then release straight into a n=5 computation
      tick(); tick();
      chk("reset_cs", cs, 0);
      chk("reset_outputs", {load_cnt, load_reg, en, sel1, sel2, done, error}, 0);
      push(0, 120, 11, 4, 1);
      mon_en = 1;
      rst_n  = 1'b1;
      tick();
      chk("init_after_reset", cs, 1);
      wait_term(60);
      // go held high: must stay in DONE, no restart
      tick(); tick(); tick();
      chk("hold_done_cs", cs, 4);
      chk("hold_done_flag", done, 1);
      go = 1'b0;
      tick();
      chk("idle_after_done", cs, 0);

      // Small n and go released mid-computation
      run(0, 0, 0, 1, 3, 0, 1);
      run(1, 0, 0, 1, 3, 0, 1);
      run(4, 1, 0, 24, 9, 3, 1);

      // Out-of-range n in IDLE
      n_in = 13;
      push(1, 0, 1, 0, 0);
      go = 1'b1;
      tick();
      chk("data_error_cs", cs, 5);
      chk("data_error_flag", error, 1);
      go = 1'b0;
      tick();
      chk("data_error_idle", cs, 0);

      // Watchdog with data_gt stuck high
      force_gt = 1;
      run(5, 0, 1, 0, 27, 12, 1);
      force_gt = 0;

      // Reset during the third MULT of an n=8 run
      n_in = 8;
      go = 1'b1;
      mults = 0;
      for (int k = 0; k < 40 && mults < 3; k++) begin
         tick();
         if (cs == 3'd3) mults++;
      end
      chk("reached_third_mult", mults, 3);
      rst_n = 1'b0;
      go = 1'b0;
      tick();
      chk("mid_reset_cs", cs, 0);
      chk("mid_reset_en", en, 0);
      chk("mid_reset_load_reg", load_reg, 0);
      rst_n = 1'b1;
      tick();
      run(3, 0, 0, 6, 7, 2, 1);

      tick(); tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
